video_blitter: RTL

//  Rectangle fill/copy engine on the CPU side of Video_RAM; drives the CPU port (address, write data, we).
//  CPU loads one command; engine walks a W x H rectangle in video memory, writing a constant byte (FILL)
//  or bytes read from a source rectangle (COPY). Top level muxes RAM port to blitter while busy=1.

---
 rtl/video_blitter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/video_blitter.sv
// ============================================================================
//  Module   : video_blitter
//  Purpose  : Rectangle FILL / COPY engine driving the CPU port of video RAM.
//             Walks a W x H rectangle in row-major order, writing a constant
//             byte (FILL) or bytes read from a source rectangle (COPY).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module video_blitter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [DIM_W-1:0]  cmd_width,
  input  logic [DIM_W-1:0]  cmd_height,
  input  logic [ADDR_W-1:0] cmd_stride,
  input  logic [DATA_W-1:0] cmd_fill,
  output logic [ADDR_W-1:0] ram_add,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_COPY_RD = 3'd2,
    S_COPY_WR = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] src_row_q, src_row_d;
  logic [ADDR_W-1:0] dst_row_q, dst_row_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] ram_add_q, ram_add_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;

  // Position of the element after the current one, plus end-of-rectangle flag.
  logic [DIM_W-1:0]  nxt_col;
  logic [DIM_W-1:0]  nxt_row;
  logic [ADDR_W-1:0] nxt_src_row;
  logic [ADDR_W-1:0] nxt_dst_row;
  logic              last_col;
  logic              last_elem;

  // Row-major stepping: advance column, or wrap to next row base (mod 2^ADDR_W).
  always_comb begin
    last_col    = (col_q == (width_q - DIM_W'(1)));
    last_elem   = last_col && (row_q == (height_q - DIM_W'(1)));
    nxt_col     = col_q + DIM_W'(1);
    nxt_row     = row_q;
    nxt_src_row = src_row_q;
    nxt_dst_row = dst_row_q;
    if (last_col) begin
      nxt_col     = '0;
      nxt_row     = row_q + DIM_W'(1);
      nxt_src_row = src_row_q + stride_q;
      nxt_dst_row = dst_row_q + stride_q;
    end
  end

  // Next-state logic; RAM port values are computed for the upcoming cycle so
  // that address/we leave the block straight from flops.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    src_row_d   = src_row_q;
    dst_row_d   = dst_row_q;
    width_d     = width_q;
    height_d    = height_q;
    stride_d    = stride_q;
    fill_d      = fill_q;
    ram_add_d   = ram_add_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (cmd_valid) begin
          width_d   = cmd_width;
          height_d  = cmd_height;
          stride_d  = cmd_stride;
          fill_d    = cmd_fill;
          col_d     = '0;
          row_d     = '0;
          src_row_d = cmd_src;
          dst_row_d = cmd_dst;
          if ((cmd_width == '0) || (cmd_height == '0)) begin
            state_d = S_DONE;
          end else if (cmd_mode) begin
            state_d   = S_COPY_RD;
            ram_add_d = cmd_src;
          end else begin
            state_d     = S_FILL;
            ram_add_d   = cmd_dst;
            ram_wdata_d = cmd_fill;
            ram_we_d    = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (last_elem) begin
          state_d = S_DONE;
        end else begin
          col_d       = nxt_col;
          row_d       = nxt_row;
          src_row_d   = nxt_src_row;
          dst_row_d   = nxt_dst_row;
          ram_add_d   = nxt_dst_row + ADDR_W'(nxt_col);
          ram_wdata_d = fill_q;
          ram_we_d    = 1'b1;
        end
      end
      S_COPY_RD: begin
        state_d   = S_COPY_WR;
        ram_add_d = dst_row_q + ADDR_W'(col_q);
        ram_we_d  = 1'b1;
      end
      S_COPY_WR: begin
        // Keep the byte just written so the data output holds it afterwards.
        ram_wdata_d = ram_rdata;
        if (last_elem) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_COPY_RD;
          col_d     = nxt_col;
          row_d     = nxt_row;
          src_row_d = nxt_src_row;
          dst_row_d = nxt_dst_row;
          ram_add_d = nxt_src_row + ADDR_W'(nxt_col);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, command and RAM port registers; async reset abandons any command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      src_row_q   <= '0;
      dst_row_q   <= '0;
      width_q     <= '0;
      height_q    <= '0;
      stride_q    <= '0;
      fill_q      <= '0;
      ram_add_q   <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      src_row_q   <= src_row_d;
      dst_row_q   <= dst_row_d;
      width_q     <= width_d;
      height_q    <= height_d;
      stride_q    <= stride_d;
      fill_q      <= fill_d;
      ram_add_q   <= ram_add_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
    end
  end

  // Read data of a synchronous RAM arrives in the write cycle itself, so the
  // copy write forwards it; the select is a registered state decode.
  assign ram_wdata = (state_q == S_COPY_WR) ? ram_rdata : ram_wdata_q;
  assign ram_add   = ram_add_q;
  assign ram_we    = ram_we_q;
  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_FILL) || (state_q == S_COPY_RD) ||
                     (state_q == S_COPY_WR);

endmodule

`default_nettype wire
